avg_filter_multi: RTL and testbench

Parametrised moving-average (boxcar) low-pass filter for the audio CODEC path. It filters CHANNELS interleaved channels of signed PCM samples over a 2^DEPTH_LOG2-sample window. One time-multiplexed add/subtract datapath serves all channels. It sits between the CODEC readdata and writedata buses, with per-sample valid/ready handshake, runtime bypass and history flush.

---
 rtl/avg_filter_multi.sv | 95 +++++++++
 tb/tb_avg_filter_multi.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/avg_filter_multi.sv
// avg_filter_multi: time-multiplexed boxcar low-pass filter over CHANNELS interleaved PCM channels
// ports: CLOCK_50/reset (sync, active-high); in_valid/in_ready/in_data input frame handshake;
// bypass selects raw frame on output; flush clears history; out_valid pulses with out_data;
// dropped pulses when a frame is offered while not ready
module avg_filter_multi #(
  parameter int WIDTH = 24,
  parameter int CHANNELS = 2,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic                      bypass,
  input  logic                      flush,
  output logic                      out_valid,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic                      dropped
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int AW = WIDTH + DEPTH_LOG2;
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  typedef enum logic [1:0] {CLEAR, IDLE, PROC, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] hist [CHANNELS][DEPTH];
  logic signed [AW-1:0] acc [CHANNELS];
  logic [DEPTH_LOG2-1:0] wptr, clr_cnt;
  logic [CW-1:0] ch;
  logic [CHANNELS*WIDTH-1:0] latched;
  logic flush_pending;
  logic [WIDTH-1:0] new_s, old_s;
  logic signed [AW-1:0] sum;
  assign in_ready = state == IDLE && !flush_pending && !flush;
  always_comb begin
    new_s = latched[ch*WIDTH +: WIDTH];
    old_s = hist[ch][wptr];
    sum = acc[ch] + $signed({{DEPTH_LOG2{new_s[WIDTH-1]}}, new_s}) - $signed({{DEPTH_LOG2{old_s[WIDTH-1]}}, old_s});
  end
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= CLEAR;
      clr_cnt <= '0;
      wptr <= '0;
      ch <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
      dropped <= 1'b0;
      flush_pending <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) acc[c] <= '0;
    end else begin
      out_valid <= 1'b0;
      dropped <= in_valid && !in_ready;
      unique case (state)
        CLEAR: begin
          for (int c = 0; c < CHANNELS; c++) hist[c][clr_cnt] <= '0;
          clr_cnt <= clr_cnt + 1'b1;
          if (&clr_cnt) begin
            for (int c = 0; c < CHANNELS; c++) acc[c] <= '0;
            wptr <= '0;
            state <= IDLE;
          end
        end
        IDLE: begin
          if (flush || flush_pending) begin
            flush_pending <= 1'b0;
            state <= CLEAR;
          end else if (in_valid) begin
            latched <= in_data;
            ch <= '0;
            state <= PROC;
          end
        end
        PROC: begin
          acc[ch] <= sum;
          hist[ch][wptr] <= new_s;
          if (flush) flush_pending <= 1'b1;
          if (ch == CW'(CHANNELS - 1)) begin
            wptr <= wptr + 1'b1;
            state <= DONE;
          end else ch <= ch + 1'b1;
        end
        DONE: begin
          // arithmetic shift by DEPTH_LOG2 is just the upper WIDTH bits of the accumulator
          for (int c = 0; c < CHANNELS; c++)
            out_data[c*WIDTH +: WIDTH] <= bypass ? latched[c*WIDTH +: WIDTH] : acc[c][AW-1:DEPTH_LOG2];
          out_valid <= 1'b1;
          if (flush) flush_pending <= 1'b1;
          state <= IDLE;
        end
        default: state <= CLEAR;
      endcase
    end
  end
endmodule

// File: tb/tb_avg_filter_multi.sv
// tb_avg_filter_multi: directed checks of avg_filter_multi (DEPTH_LOG2=2 main instance, DEPTH_LOG2=4 for reset timing)
module tb_avg_filter_multi;
  logic CLOCK_50 = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic bypass = 1'b0;
  logic flush = 1'b0;
  logic [47:0] in_data = '0;
  logic in_ready, out_valid, dropped;
  logic [47:0] out_data;
  logic in_ready4, out_valid4, dropped4;
  logic [47:0] out_data4;
  int total = 0;
  int bad = 0;
  always #10 CLOCK_50 = ~CLOCK_50;
  avg_filter_multi #(.WIDTH(24), .CHANNELS(2), .DEPTH_LOG2(2)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .bypass(bypass), .flush(flush), .out_valid(out_valid), .out_data(out_data), .dropped(dropped)
  );
  avg_filter_multi #(.WIDTH(24), .CHANNELS(2), .DEPTH_LOG2(4)) dut4 (
    .CLOCK_50(CLOCK_50), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .bypass(bypass), .flush(flush), .out_valid(out_valid4), .out_data(out_data4), .dropped(dropped4)
  );
  task automatic wait_ready();
    for (int n = 0; n < 100 && !in_ready; n++) begin
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
    end
  endtask
  task automatic xfer(input logic [47:0] d, input logic fl, output logic [47:0] q, output int lat);
    wait_ready();
    lat = -1;
    q = '0;
    in_valid = 1'b1;
    in_data = d;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    in_valid = 1'b0;
    flush = fl;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      flush = 1'b0;
      if (out_valid) begin
        lat = i;
        q = out_data;
      end
    end
  endtask
  task automatic flush_hist();
    flush = 1'b1;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    flush = 1'b0;
    wait_ready();
  endtask
  task automatic test_reset();
    int n2, n4;
    reset = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    total++;
    if (in_ready4 !== 1'b0 || out_valid4 !== 1'b0 || dropped4 !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: in_ready=%b out_valid=%b dropped=%b, need 0 0 0", in_ready4, out_valid4, dropped4);
    end
    total++;
    if (out_data4 !== 48'h0) begin
      bad++;
      $display("FAIL reset_out_data: got %h need 0", out_data4);
    end
    reset = 1'b0;
    n2 = -1;
    n4 = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      if (in_ready && n2 < 0) n2 = i;
      if (in_ready4 && n4 < 0) n4 = i;
    end
    total++;
    if (n4 !== 16) begin
      bad++;
      $display("FAIL reset_clear_depth16: in_ready rose after %0d cycles, need 16", n4);
    end
    total++;
    if (n2 !== 4) begin
      bad++;
      $display("FAIL reset_clear_depth4: in_ready rose after %0d cycles, need 4", n2);
    end
    total++;
    if (out_data4 !== 48'h0 || out_data !== 48'h0) begin
      bad++;
      $display("FAIL reset_idle_out_data: got %h / %h need 0", out_data4, out_data);
    end
  endtask
  task automatic test_step();
    logic [23:0] exp0 [5] = '{24'd100, 24'd200, 24'd300, 24'd400, 24'd400};
    logic [47:0] q;
    int lat;
    for (int k = 0; k < 5; k++) begin
      xfer({24'd0, 24'd400}, 1'b0, q, lat);
      total++;
      if (q[23:0] !== exp0[k] || q[47:24] !== 24'd0) begin
        bad++;
        $display("FAIL step_frame%0d: got ch0=%0d ch1=%0d need ch0=%0d ch1=0", k, q[23:0], q[47:24], exp0[k]);
      end
      total++;
      if (lat !== 3) begin
        bad++;
        $display("FAIL step_latency%0d: got %0d need 3", k, lat);
      end
    end
  endtask
  task automatic test_neg_round();
    logic [23:0] exp1 [8] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'h000000, 24'h000000, 24'h000001};
    logic [47:0] q;
    int lat;
    flush_hist();
    for (int k = 0; k < 8; k++) begin
      xfer(k < 4 ? {24'hFFFFFF, 24'd0} : {24'd1, 24'd0}, 1'b0, q, lat);
      total++;
      if (q[47:24] !== exp1[k] || q[23:0] !== 24'd0) begin
        bad++;
        $display("FAIL neg_round%0d: got ch1=%h ch0=%h need ch1=%h ch0=0", k, q[47:24], q[23:0], exp1[k]);
      end
    end
  endtask
  task automatic test_full_scale();
    logic [23:0] exp [8] = '{24'h1FFFFF, 24'h3FFFFF, 24'h5FFFFF, 24'h7FFFFF, 24'h3FFFFF, 24'hFFFFFF, 24'hBFFFFF, 24'h800000};
    logic [47:0] q;
    int lat;
    flush_hist();
    for (int k = 0; k < 8; k++) begin
      xfer(k < 4 ? {24'h7FFFFF, 24'h7FFFFF} : {24'h800000, 24'h800000}, 1'b0, q, lat);
      total++;
      if (q !== {exp[k], exp[k]}) begin
        bad++;
        $display("FAIL full_scale%0d: got %h need %h", k, q, {exp[k], exp[k]});
      end
    end
  endtask
  task automatic test_bypass_overrun();
    int cnt;
    logic [47:0] q;
    flush_hist();
    bypass = 1'b1;
    in_valid = 1'b1;
    in_data = {24'h000123, 24'hFFFF00};
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    in_valid = 1'b0;
    total++;
    if (dropped !== 1'b1) begin
      bad++;
      $display("FAIL overrun_dropped: got %b need 1", dropped);
    end
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    total++;
    if (dropped !== 1'b0) begin
      bad++;
      $display("FAIL overrun_dropped_pulse: got %b need 0", dropped);
    end
    cnt = 0;
    q = '0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) begin
        cnt++;
        q = out_data;
      end
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
    end
    bypass = 1'b0;
    total++;
    if (cnt !== 1) begin
      bad++;
      $display("FAIL overrun_out_count: got %0d need 1", cnt);
    end
    total++;
    if (q !== 48'h000123FFFF00) begin
      bad++;
      $display("FAIL bypass_data: got %h need 000123ffff00", q);
    end
  endtask
  task automatic test_flush_mid();
    logic [47:0] q;
    int lat;
    flush_hist();
    for (int k = 0; k < 4; k++) xfer({24'd0, 24'd400}, 1'b0, q, lat);
    total++;
    if (q[23:0] !== 24'd400) begin
      bad++;
      $display("FAIL flush_warmup: got %0d need 400", q[23:0]);
    end
    xfer({24'd0, 24'd400}, 1'b1, q, lat);
    total++;
    if (q[23:0] !== 24'd400 || lat !== 3) begin
      bad++;
      $display("FAIL flush_current_frame: got %0d lat=%0d need 400 lat=3", q[23:0], lat);
    end
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL flush_pending_ready: got %b need 0", in_ready);
    end
    xfer({24'd0, 24'd400}, 1'b0, q, lat);
    total++;
    if (q[23:0] !== 24'd100 || lat !== 3) begin
      bad++;
      $display("FAIL flush_restart: got %0d lat=%0d need 100 lat=3", q[23:0], lat);
    end
  endtask
  initial begin
    @(negedge CLOCK_50);
    test_reset();
    test_step();
    test_neg_round();
    test_full_scale();
    test_bypass_overrun();
    test_flush_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
